unified_mem: RTL and testbench

UNIFIED_MEM -- requirements
Module: unified_mem

---
 rtl/unified_mem_if.sv | 37 +++
 rtl/unified_mem.sv | 131 +++++++++++++
 tb/tb_unified_mem.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/unified_mem_if.sv
// Line-memory bus between the cache controller and unified_mem.
// err exists only when MEM_ERR_EN is defined.
interface unified_mem_if;
  logic        m_re;
  logic        m_we;
  logic [13:0] m_addr;
  logic [63:0] m_data;
  logic [63:0] m_out;
  logic        m_rdy;
`ifdef MEM_ERR_EN
  logic        err;
`endif

  modport master (
    output m_re,
    output m_we,
    output m_addr,
    output m_data,
    input  m_out,
    input  m_rdy
`ifdef MEM_ERR_EN
    ,input err
`endif
  );

  modport slave (
    input  m_re,
    input  m_we,
    input  m_addr,
    input  m_data,
    output m_out,
    output m_rdy
`ifdef MEM_ERR_EN
    ,output err
`endif
  );
endinterface

// File: rtl/unified_mem.sv
// Fixed-latency 64-bit line memory, one op in flight (IDLE/BUSY).
// Optional MEM_ERR_EN adds err pulse and out-of-range blocking.
module unified_mem #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 16384
) (
  input logic         clk,
  input logic         rst_n,
  unified_mem_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [63:0] out_q, out_d;
  logic        rdy_q, rdy_d;

  logic [63:0] mem [DEPTH];

  logic          req;
  logic          accept;
  logic          done;
  logic          in_rng;
  logic          wr_en;
  logic [AW-1:0] idx;

  assign req    = bus.m_re | bus.m_we;
  assign accept = (state_q == IDLE) & req & ~rdy_q;
  assign done   = (state_q == BUSY) & (cnt_q == 4'd0);

`ifdef MEM_ERR_EN
  logic err_q, err_d;
  logic in_ok;

  // Out-of-range lines are blocked instead of aliased.
  assign in_rng = 32'(addr_q) < DEPTH;
  assign idx    = AW'(addr_q);
  assign in_ok  = 32'(bus.m_addr) < DEPTH;

  always_comb begin
    err_d = 1'b0;
    if (accept && bus.m_re && bus.m_we)
      err_d = 1'b1;
    if ((state_q == IDLE) && req && !in_ok)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign in_rng = 1'b1;
  assign idx    = AW'(32'(addr_q) % DEPTH);
`endif

  assign wr_en = done & we_q & in_rng;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    out_d   = out_q;
    rdy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.m_we;
          addr_d  = bus.m_addr;
          data_d  = bus.m_data;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q)
            out_d = in_rng ? mem[idx] : '0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
    end
  end

  // Array is never reset; write only fires from a live BUSY state.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[idx] <= data_q;
  end

  assign bus.m_out = out_q;
  assign bus.m_rdy = rdy_q;

endmodule

// File: tb/tb_unified_mem.sv
// Scoreboard bench for unified_mem: LATENCY=4 full-depth and
// LATENCY=1 DEPTH=16 instances sharing clock and reset.
module tb_unified_mem;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic        rd;
    logic [63:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] lr [2];

  unified_mem_if b0();
  unified_mem_if b1();

  unified_mem #(.LATENCY(4), .DEPTH(16384)) u0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0)
  );

  unified_mem #(.LATENCY(1), .DEPTH(16)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic cmp(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk(input int u, input logic [63:0] out);
    exp_t e;
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rdy u%0d at cyc %0d want none", u, cyc);
      return;
    end
    e = (u == 0) ? q0.pop_front() : q1.pop_front();
    cmp($sformatf("rdy_cycle_u%0d", u), 64'(cyc), 64'(e.cyc));
    if (e.rd) begin
      cmp($sformatf("rd_data_u%0d", u), out, e.data);
      lr[u] = e.data;
    end else begin
      cmp($sformatf("wr_out_hold_u%0d", u), out, lr[u]);
    end
  endtask

  always @(negedge clk) begin
    if (b0.m_rdy) chk(0, b0.m_out);
    if (b1.m_rdy) chk(1, b1.m_out);
  end

  // Issue at a negedge; returns at the negedge where m_rdy is due,
  // still driving the request.
  task automatic op(input int u, input logic we, input logic re,
                    input logic [13:0] a, input logic [63:0] d,
                    input int dly);
    exp_t e;
    int   lat;
    lat    = (u == 0) ? 4 : 1;
    e.cyc  = cyc + dly + lat;
    e.rd   = !we;
    e.data = d;
    if (u == 0) begin
      b0.m_we = we; b0.m_re = re; b0.m_addr = a; b0.m_data = d;
      q0.push_back(e);
    end else begin
      b1.m_we = we; b1.m_re = re; b1.m_addr = a; b1.m_data = d;
      q1.push_back(e);
    end
    repeat (dly + lat) @(negedge clk);
  endtask

  // Keep the request across the m_rdy edge (must be dropped), then release.
  task automatic idle(input int u);
    @(negedge clk);
    if (u == 0) begin
      b0.m_we = 1'b0; b0.m_re = 1'b0;
    end else begin
      b1.m_we = 1'b0; b1.m_re = 1'b0;
    end
  endtask

  initial begin
    lr[0] = '0;
    lr[1] = '0;
    b0.m_we = 1'b0; b0.m_re = 1'b0; b0.m_addr = '0; b0.m_data = '0;
    b1.m_we = 1'b0; b1.m_re = 1'b0; b1.m_addr = '0; b1.m_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst_rdy_u0", 64'(b0.m_rdy), 64'd0);
    cmp("rst_out_u0", b0.m_out, 64'd0);
    cmp("rst_rdy_u1", 64'(b1.m_rdy), 64'd0);
    cmp("rst_out_u1", b1.m_out, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op(0, 1'b1, 1'b0, 14'h0010, 64'h1111_2222_3333_4444, 1);
    idle(0);
    op(0, 1'b0, 1'b1, 14'h0010, 64'h1111_2222_3333_4444, 1);
    idle(0);

    op(0, 1'b1, 1'b0, 14'h3C05, 64'hA5A5_0000_5A5A_FFFF, 1);
    op(0, 1'b0, 1'b1, 14'h3C05, 64'hA5A5_0000_5A5A_FFFF, 2);
    idle(0);
    repeat (3) @(negedge clk);
    cmp("out_hold", b0.m_out, 64'hA5A5_0000_5A5A_FFFF);
    cmp("rdy_low_idle", 64'(b0.m_rdy), 64'd0);

    op(0, 1'b1, 1'b0, 14'h0020, 64'h0BAD_F00D_0000_0001, 1);
    idle(0);

    op(0, 1'b1, 1'b1, 14'h0030, 64'hC0C0_C0C0_1234_5678, 1);
    idle(0);
    op(0, 1'b0, 1'b1, 14'h0030, 64'hC0C0_C0C0_1234_5678, 1);
    idle(0);

    op(0, 1'b1, 1'b0, 14'h0001, 64'h0123_4567_89AB_CDEF, 1);
    idle(0);
    b0.m_we = 1'b1; b0.m_addr = 14'h0001; b0.m_data = 64'hDEAD;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    b0.m_we = 1'b0;
    #1;
    cmp("midrst_rdy", 64'(b0.m_rdy), 64'd0);
    cmp("midrst_out", b0.m_out, 64'd0);
    lr[0] = '0;
    lr[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 1'b0, 1'b1, 14'h0001, 64'h0123_4567_89AB_CDEF, 1);
    idle(0);

    op(1, 1'b1, 1'b0, 14'h0005, 64'h5555_6666_7777_8888, 1);
    idle(1);
    op(1, 1'b0, 1'b1, 14'h0015, 64'h5555_6666_7777_8888, 1);
    op(1, 1'b0, 1'b1, 14'h0015, 64'h5555_6666_7777_8888, 2);
    idle(1);

    repeat (8) @(negedge clk);
    cmp("q0_drained", 64'(q0.size()), 64'd0);
    cmp("q1_drained", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
